// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared constants and entry record for the store buffer
package sb_pkg;
  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_WORD_OFS      = 2;
  // Entry address field is sized for the widest supported AW; narrower addresses are zero-extended.
  localparam int SB_MAX_AW        = 64;

  typedef struct packed {
    logic [SB_MAX_AW-1:0] addr;
    logic [31:0]          data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest-match word-address search over occupied buffer entries
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  sb_entry_t                entries_i [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head_i,
  input  logic [$clog2(DEPTH):0]   count_i,
  input  logic [SB_MAX_AW-1:0]     rd_addr_i,
  output logic                     hit_o,
  output logic [31:0]              data_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PW'(k);
      if ((CW'(k) < count_i) &&
          (((entries_i[idx].addr ^ rd_addr_i) >> SB_WORD_OFS) == '0)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - FIFO store buffer between core and data memory with load forwarding
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [AW-1:0]            DataAdr,
  input  logic [31:0]              WriteData,
  output logic                     Stall,
  input  logic [AW-1:0]            ReadAdr,
  output logic                     FwdHit,
  output logic [31:0]              FwdData,
  output logic                     MemReq,
  output logic [AW-1:0]            MemAdr,
  output logic [31:0]              MemWData,
  input  logic                     MemReady,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, push, pop;

  assign full = (count_q == CW'(DEPTH));
  assign push = MemWrite && !full;
  assign pop  = (count_q != '0) && MemReady;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy is defined by head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= '{addr: SB_MAX_AW'(DataAdr), data: WriteData};
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .rd_addr_i (SB_MAX_AW'(ReadAdr)),
    .hit_o     (FwdHit),
    .data_o    (FwdData)
  );

  assign Stall    = full;
  assign MemReq   = (count_q != '0);
  assign Empty    = (count_q == '0);
  assign Count    = count_q;
  assign MemAdr   = mem_q[head_q].addr[AW-1:0];
  assign MemWData = mem_q[head_q].data;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - table-driven directed bench for store_buffer
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        Stall;
  logic [31:0] ReadAdr;
  logic        FwdHit;
  logic [31:0] FwdData;
  logic        MemReq;
  logic [31:0] MemAdr;
  logic [31:0] MemWData;
  logic        MemReady;
  logic        Empty;
  logic [2:0]  Count;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .Stall     (Stall),
    .ReadAdr   (ReadAdr),
    .FwdHit    (FwdHit),
    .FwdData   (FwdData),
    .MemReq    (MemReq),
    .MemAdr    (MemAdr),
    .MemWData  (MemWData),
    .MemReady  (MemReady),
    .Empty     (Empty),
    .Count     (Count)
  );

  typedef struct {
    logic        mw;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] rd;
    logic        hit;
    logic [31:0] fd;
    logic [31:0] madr;
    logic [31:0] mwd;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t v(logic mw, logic [31:0] adr, logic [31:0] wd, logic rdy,
                             logic [31:0] rd, logic hit, logic [31:0] fd,
                             logic [31:0] madr, logic [31:0] mwd, logic [2:0] cnt);
    vec_t r;
    r.mw = mw; r.adr = adr; r.wd = wd; r.rdy = rdy; r.rd = rd;
    r.hit = hit; r.fd = fd; r.madr = madr; r.mwd = mwd; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] cnt, input logic hit,
                             input logic [31:0] fd);
    check({tag, " Count"},   32'(Count),   32'(cnt));
    check({tag, " Stall"},   32'(Stall),   32'(cnt == 3'd4));
    check({tag, " MemReq"},  32'(MemReq),  32'(cnt != 3'd0));
    check({tag, " Empty"},   32'(Empty),   32'(cnt == 3'd0));
    check({tag, " FwdHit"},  32'(FwdHit),  32'(hit));
    check({tag, " FwdData"}, FwdData,      fd);
  endtask

  initial begin
    // mw adr wd rdy rd | hit fd madr mwd cnt
    vq.push_back(v(0,   0,  0, 0,   0, 0,  0,   0,  0, 0)); // reset state
    vq.push_back(v(1, 100, 25, 1, 100, 0,  0,   0,  0, 0)); // same-cycle push not forwarded
    vq.push_back(v(0,   0,  0, 1, 100, 1, 25, 100, 25, 1)); // head visible in its pop cycle
    vq.push_back(v(0,   0,  0, 0, 100, 0,  0,   0,  0, 0));
    vq.push_back(v(1,  96,  1, 0,   0, 0,  0,   0,  0, 0)); // fill
    vq.push_back(v(1, 100,  2, 0,   0, 0,  0,  96,  1, 1));
    vq.push_back(v(1, 104,  3, 0,   0, 0,  0,  96,  1, 2));
    vq.push_back(v(1, 108,  4, 0,   0, 0,  0,  96,  1, 3));
    vq.push_back(v(1, 112,  5, 0,   0, 0,  0,  96,  1, 4));
    vq.push_back(v(1, 112,  5, 0, 112, 0,  0,  96,  1, 4)); // 5th push ignored
    vq.push_back(v(0,   0,  0, 1,   0, 0,  0,  96,  1, 4)); // drain in order
    vq.push_back(v(0,   0,  0, 1,   0, 0,  0, 100,  2, 3));
    vq.push_back(v(0,   0,  0, 1,   0, 0,  0, 104,  3, 2));
    vq.push_back(v(0,   0,  0, 1,   0, 0,  0, 108,  4, 1));
    vq.push_back(v(0,   0,  0, 0,   0, 0,  0,   0,  0, 0));
    vq.push_back(v(1, 200, 10, 0,   0, 0,  0,   0,  0, 0)); // push+pop at Count=2
    vq.push_back(v(1, 204, 11, 0,   0, 0,  0, 200, 10, 1));
    vq.push_back(v(1, 208, 12, 1,   0, 0,  0, 200, 10, 2));
    vq.push_back(v(0,   0,  0, 0,   0, 0,  0, 204, 11, 2));
    vq.push_back(v(0,   0,  0, 1,   0, 0,  0, 204, 11, 2));
    vq.push_back(v(0,   0,  0, 1,   0, 0,  0, 208, 12, 1));
    vq.push_back(v(0,   0,  0, 0,   0, 0,  0,   0,  0, 0));
    vq.push_back(v(1, 100,  7, 0,   0, 0,  0,   0,  0, 0)); // forwarding youngest
    vq.push_back(v(1, 100, 25, 0, 102, 1,  7, 100,  7, 1));
    vq.push_back(v(0,   0,  0, 0, 102, 1, 25, 100,  7, 2));
    vq.push_back(v(0,   0,  0, 0, 200, 0,  0, 100,  7, 2));
    vq.push_back(v(0,   0,  0, 1, 101, 1, 25, 100,  7, 2));
    vq.push_back(v(0,   0,  0, 1, 100, 1, 25, 100, 25, 1));
    vq.push_back(v(0,   0,  0, 0, 100, 0,  0,   0,  0, 0));
    vq.push_back(v(1, 300, 30, 0,   0, 0,  0,   0,  0, 0)); // full + pop: held push waits
    vq.push_back(v(1, 304, 31, 0,   0, 0,  0, 300, 30, 1));
    vq.push_back(v(1, 308, 32, 0,   0, 0,  0, 300, 30, 2));
    vq.push_back(v(1, 312, 33, 0,   0, 0,  0, 300, 30, 3));
    vq.push_back(v(1, 316, 34, 1,   0, 0,  0, 300, 30, 4));
    vq.push_back(v(1, 316, 34, 0,   0, 0,  0, 304, 31, 3));
    vq.push_back(v(0,   0,  0, 0, 316, 1, 34, 304, 31, 4));

    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    MemReady = 1'b1; ReadAdr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      MemWrite  = vq[i].mw;
      DataAdr   = vq[i].adr;
      WriteData = vq[i].wd;
      MemReady  = vq[i].rdy;
      ReadAdr   = vq[i].rd;
      #1;
      n_vec++;
      check_state($sformatf("vec%0d", i), vq[i].cnt, vq[i].hit, vq[i].fd);
      if (vq[i].cnt != 3'd0) begin
        check($sformatf("vec%0d MemAdr", i),   MemAdr,   vq[i].madr);
        check($sformatf("vec%0d MemWData", i), MemWData, vq[i].mwd);
      end
      @(negedge clk);
    end

    // Mid-operation reset with three entries buffered.
    MemWrite = 1'b0; MemReady = 1'b1; ReadAdr = 32'd308;
    #1; n_vec++;
    check_state("pre_reset4", 3'd4, 1'b1, 32'd32);
    @(negedge clk);
    MemReady = 1'b0;
    #1; n_vec++;
    check_state("pre_reset3", 3'd3, 1'b1, 32'd32);
    check("pre_reset3 MemAdr", MemAdr, 32'd308);
    reset = 1'b1; MemWrite = 1'b1; DataAdr = 32'd400; WriteData = 32'd40; MemReady = 1'b1;
    @(negedge clk);
    reset = 1'b0; MemWrite = 1'b0;
    #1; n_vec++;
    check_state("post_reset", 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    ReadAdr = 32'd400;
    #1; n_vec++;
    check_state("post_reset_idle", 3'd0, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered stores; power of two, 2..16.
REQ-002 SHALL have parameter AW, default 32: address width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port MemWrite, input, 1 bit: core store request this cycle.
REQ-006 SHALL have port DataAdr, input, AW bits: core store byte address.
REQ-007 SHALL have port WriteData, input, 32 bits: core store data.
REQ-008 SHALL have port Stall, output, 1 bit: buffer full; core must hold its store.
REQ-009 SHALL have port ReadAdr, input, AW bits: core load address for the forwarding lookup.
REQ-010 SHALL have port FwdHit, output, 1 bit: a buffered store matches ReadAdr.
REQ-011 SHALL have port FwdData, output, 32 bits: data from the youngest matching entry.
REQ-012 SHALL have port MemReq, output, 1 bit: head entry valid toward data memory.
REQ-013 SHALL have port MemAdr, output, AW bits: head entry address.
REQ-014 SHALL have port MemWData, output, 32 bits: head entry data.
REQ-015 SHALL have port MemReady, input, 1 bit: memory accepts the head entry this cycle.
REQ-016 SHALL have port Empty, output, 1 bit: no buffered entries.
REQ-017 SHALL have port Count, output, log2(DEPTH)+1 bits: number of occupied entries.

Function
REQ-018 SHALL push {DataAdr, WriteData} at the tail on a rising edge when MemWrite=1 and Count<DEPTH.
REQ-019 SHALL drive Stall=1 exactly when Count==DEPTH; Stall SHALL depend only on registered state, with no combinational path from MemReady or MemWrite.
REQ-020 SHALL ignore MemWrite while Stall=1, leaving all state unchanged; no entry is dropped or overwritten.
REQ-021 SHALL drive MemReq=1 whenever Count>0, with MemAdr and MemWData taken from the head entry.
REQ-022 SHALL hold MemAdr and MemWData stable while MemReq=1 and MemReady=0.
REQ-023 SHALL pop the head entry on a rising edge when MemReq=1 and MemReady=1; MemReady SHALL be ignored when Count==0.
REQ-024 SHALL keep Count unchanged on a simultaneous push and pop, moving both pointers; this is legal at any Count<DEPTH.
REQ-025 SHALL, when full, take no push in the cycle of a pop; the core's held store enters on the following edge.
REQ-026 SHALL wrap head and tail pointers modulo DEPTH, with Count tracked separately for the full/empty distinction.
REQ-027 SHALL preserve FIFO order: memory sees stores in core issue order.
REQ-028 SHALL compute FwdHit combinationally as 1 when any occupied entry has address bits [AW-1:2] equal to ReadAdr[AW-1:2].
REQ-029 SHALL drive FwdData from the youngest such entry (closest to the tail) when several entries match.
REQ-030 SHALL drive FwdData=0 when FwdHit=0.
REQ-031 SHALL exclude from forwarding a store being pushed in the same cycle; it becomes visible the next cycle.
REQ-032 SHALL keep the head entry visible to forwarding during its pop cycle.
REQ-033 SHALL store all stores as full 32-bit words; there are no byte enables.
REQ-034 SHALL drive Empty=1 exactly when Count==0.

Reset
REQ-035 SHALL, on a rising edge with reset=1, set head=0, tail=0 and Count=0, overriding any push or pop in that cycle.
REQ-036 SHALL output after reset: Stall=0, MemReq=0, Empty=1, FwdHit=0, FwdData=0; MemAdr and MemWData are don't-care while MemReq=0.
REQ-037 SHALL not reset the entry storage arrays.
REQ-038 SHALL discard buffered entries on a reset asserted mid-operation, with no further MemReq.

Structure
REQ-039 SHALL place the DEPTH default, the word-offset constant (2) and the entry record type {addr, data} in a shared package, sb_pkg.
REQ-040 SHALL implement the youngest-match priority search in one sub-module, sb_fwd_match, which is combinational and parameterised by DEPTH.
REQ-041 SHALL keep all other logic (pointers, count, storage) in store_buffer.

Verification
REQ-042 Single store: push DataAdr=100, WriteData=25 with MemReady=1 -> the next cycle gives MemReq=1, MemAdr=100, MemWData=25; Empty=1 after the pop edge.
REQ-043 Fill: 4 pushes (addresses 96, 100, 104, 108) with MemReady=0 -> Stall=1 and Count=4; a 5th push is ignored; raising MemReady drains the entries in order 96, 100, 104, 108.
REQ-044 Simultaneous push and pop at Count=2 -> Count stays 2 and order is preserved.
REQ-045 Forwarding: buffer (100, 7) then (100, 25), ReadAdr=102 -> FwdHit=1, FwdData=25; ReadAdr=200 -> FwdHit=0, FwdData=0.
REQ-046 Same-cycle push to 100 with ReadAdr=100 and an empty buffer -> FwdHit=0 that cycle, FwdHit=1 the next cycle.
REQ-047 Reset asserted with Count=3 -> the next cycle gives Count=0, MemReq=0, Stall=0, Empty=1.
